td4_exec: RTL and testbench

Execute stage of the TD4 core, sitting directly downstream of the program counter and the instruction ROM. Each cycle it decodes the 8-bit instruction fetched at the current PC value and updates registers A, B, OUT and the carry flag. It also drives the PC's load request and 4-bit `data_in`, closing the fetch/execute loop.

---
 rtl/td4_pkg.sv | 34 +++
 rtl/td4_decode.sv | 37 +++
 rtl/td4_exec.sv | 78 +++++++
 tb/tb_td4_exec.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 execute stage: datapath width, opcodes and
// the source/destination select encodings produced by the decoder.
package td4_pkg;

  localparam int DATA_W = 4;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    DST_A    = 2'd0,
    DST_B    = 2'd1,
    DST_OUT  = 2'd2,
    DST_NONE = 2'd3
  } dst_sel_e;

endpackage

// File: rtl/td4_decode.sv
// Combinational opcode decoder. Undefined opcodes and jumps select a zero
// source with no destination so the adder produces no carry.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [1:0] src_sel_o,
  output logic [1:0] dst_sel_o,
  output logic       use_imm_o,
  output logic       jmp_o,
  output logic       jnc_o
);

  always_comb begin
    src_sel_o = SRC_ZERO;
    dst_sel_o = DST_NONE;
    use_imm_o = 1'b0;
    jmp_o     = 1'b0;
    jnc_o     = 1'b0;
    case (opcode_i)
      OP_ADD_A:  begin src_sel_o = SRC_A;  dst_sel_o = DST_A;   use_imm_o = 1'b1; end
      OP_MOV_AB: begin src_sel_o = SRC_B;  dst_sel_o = DST_A;   end
      OP_IN_A:   begin src_sel_o = SRC_IN; dst_sel_o = DST_A;   end
      OP_MOV_AI: begin                     dst_sel_o = DST_A;   use_imm_o = 1'b1; end
      OP_MOV_BA: begin src_sel_o = SRC_A;  dst_sel_o = DST_B;   end
      OP_ADD_B:  begin src_sel_o = SRC_B;  dst_sel_o = DST_B;   use_imm_o = 1'b1; end
      OP_IN_B:   begin src_sel_o = SRC_IN; dst_sel_o = DST_B;   end
      OP_MOV_BI: begin                     dst_sel_o = DST_B;   use_imm_o = 1'b1; end
      OP_OUT_B:  begin src_sel_o = SRC_B;  dst_sel_o = DST_OUT; end
      OP_OUT_I:  begin                     dst_sel_o = DST_OUT; use_imm_o = 1'b1; end
      OP_JNC:    jnc_o = 1'b1;
      OP_JMP:    begin jmp_o = 1'b1; use_imm_o = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4_exec.sv
// TD4 execute stage: source mux, 4-bit adder, A/B/OUT registers, carry flop
// and the PC load request that closes the fetch/execute loop.
module td4_exec
  import td4_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [7:0]        instr,
  input  logic [DATA_W-1:0] in_port,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_data,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] a_q,
  output logic [DATA_W-1:0] b_q,
  output logic              carry_q
);

  logic [1:0]        src_sel;
  logic [1:0]        dst_sel;
  logic              use_imm;
  logic              jmp;
  logic              jnc;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] imm_eff;
  logic [DATA_W:0]   sum_d;
  logic [DATA_W-1:0] out_q;

  assign imm = instr[DATA_W-1:0];

  td4_decode u_decode (
    .opcode_i  (instr[7:4]),
    .src_sel_o (src_sel),
    .dst_sel_o (dst_sel),
    .use_imm_o (use_imm),
    .jmp_o     (jmp),
    .jnc_o     (jnc)
  );

  always_comb begin
    src = '0;
    case (src_sel)
      SRC_A:   src = a_q;
      SRC_B:   src = b_q;
      SRC_IN:  src = in_port;
      default: src = '0;
    endcase
  end

  assign imm_eff = use_imm ? imm : '0;
  assign sum_d   = {1'b0, src} + {1'b0, imm_eff};

  // JNC tests the carry left by the previous instruction, before this edge updates it.
  assign pc_load  = en & reset & (jmp | (jnc & ~carry_q));
  assign pc_data  = imm;
  assign out_port = out_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else if (en) begin
      carry_q <= sum_d[DATA_W];
      case (dst_sel)
        DST_A:   a_q   <= sum_d[DATA_W-1:0];
        DST_B:   b_q   <= sum_d[DATA_W-1:0];
        DST_OUT: out_q <= sum_d[DATA_W-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_exec.sv
// Bench for td4_exec: a directed vector table followed by a randomised run
// checked against an instruction-level model of the TD4 ISA.
module tb_td4_exec;

  localparam int W = 18;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] instr;
  logic [3:0] in_port;
  logic       pc_load;
  logic [3:0] pc_data;
  logic [3:0] out_port;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       carry_q;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic       pcl_s;
  logic [3:0] pcd_s;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       en;
    logic [7:0] instr;
    logic [3:0] in_port;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] o;
    logic       c;
    logic       pcl;
    logic [3:0] pcd;
  } vec_t;

  vec_t vecs[$];

  td4_exec #(.DATA_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .instr    (instr),
    .in_port  (in_port),
    .pc_load  (pc_load),
    .pc_data  (pc_data),
    .out_port (out_port),
    .a_q      (a_q),
    .b_q      (b_q),
    .carry_q  (carry_q)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pk(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] o, input logic c,
                                      input logic l, input logic [3:0] d);
    return {a, b, o, c, l, d};
  endfunction

  // pc_load/pc_data are sampled before the edge, registers #1 after it.
  task automatic step(input string name, input logic rst_v, input logic en_v,
                      input logic [7:0] ins, input logic [3:0] inp,
                      input logic [W-1:0] exp);
    logic [W-1:0] got;
    logic [W-1:0] want;
    reset = rst_v; en = en_v; instr = ins; in_port = inp;
    exp_q.push_back(exp);
    #1;
    pcl_s = pc_load;
    pcd_s = pc_data;
    @(posedge clk);
    #1;
    got  = pk(a_q, b_q, out_port, carry_q, pcl_s, pcd_s);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s instr=%h: got a=%h b=%h out=%h c=%b pcl=%b pcd=%h, want a=%h b=%h out=%h c=%b pcl=%b pcd=%h",
               name, ins, got[17:14], got[13:10], got[9:6], got[5], got[4], got[3:0],
               want[17:14], want[13:10], want[9:6], want[5], want[4], want[3:0]);
    end
  endtask

  task automatic add(input string n, input logic r, input logic e, input logic [7:0] i,
                     input logic [3:0] p, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] o, input logic c, input logic l, input logic [3:0] d);
    vec_t v;
    v.name = n; v.rst_n = r; v.en = e; v.instr = i; v.in_port = p;
    v.a = a; v.b = b; v.o = o; v.c = c; v.pcl = l; v.pcd = d;
    vecs.push_back(v);
  endtask

  logic [3:0] m_a, m_b, m_o;
  logic       m_c;

  initial begin
    reset = 1'b0; en = 1'b1; instr = 8'h00; in_port = 4'h0;

    //   name          rst en instr in   a     b     out   c  pcl pcd
    add("reset0",      0, 1, 8'hF5, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h5);
    add("reset1",      0, 1, 8'hF5, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h5);
    add("rel_jmp",     1, 1, 8'hF5, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 4'h5);
    add("mov_a_14",    1, 1, 8'h3E, 4'h0, 4'hE, 4'h0, 4'h0, 0, 0, 4'hE);
    add("add_a_3",     1, 1, 8'h03, 4'h0, 4'h1, 4'h0, 4'h0, 1, 0, 4'h3);
    add("mov_b_a",     1, 1, 8'h40, 4'h0, 4'h1, 4'h1, 4'h0, 0, 0, 4'h0);
    add("mov_a_15",    1, 1, 8'h3F, 4'h0, 4'hF, 4'h1, 4'h0, 0, 0, 4'hF);
    add("add_ovf",     1, 1, 8'h01, 4'h0, 4'h0, 4'h1, 4'h0, 1, 0, 4'h1);
    add("jnc_taken_c", 1, 1, 8'hE7, 4'h0, 4'h0, 4'h1, 4'h0, 0, 0, 4'h7);
    add("mov_a_15b",   1, 1, 8'h3F, 4'h0, 4'hF, 4'h1, 4'h0, 0, 0, 4'hF);
    add("add_a_0",     1, 1, 8'h00, 4'h0, 4'hF, 4'h1, 4'h0, 0, 0, 4'h0);
    add("jnc_jump",    1, 1, 8'hE7, 4'h0, 4'hF, 4'h1, 4'h0, 0, 1, 4'h7);
    add("in_a",        1, 1, 8'h20, 4'hA, 4'hA, 4'h1, 4'h0, 0, 0, 4'h0);
    add("mov_b_a2",    1, 1, 8'h40, 4'hA, 4'hA, 4'hA, 4'h0, 0, 0, 4'h0);
    add("out_b",       1, 1, 8'h90, 4'hA, 4'hA, 4'hA, 4'hA, 0, 0, 4'h0);
    add("out_im",      1, 1, 8'hB6, 4'hA, 4'hA, 4'hA, 4'h6, 0, 0, 4'h6);
    add("add_a_7",     1, 1, 8'h07, 4'h0, 4'h1, 4'hA, 4'h6, 1, 0, 4'h7);
    add("en0_add",     1, 0, 8'h05, 4'h0, 4'h1, 4'hA, 4'h6, 1, 0, 4'h5);
    add("en0_jmp",     1, 0, 8'hFF, 4'h0, 4'h1, 4'hA, 4'h6, 1, 0, 4'hF);
    add("nop_c3",      1, 1, 8'hC3, 4'h0, 4'h1, 4'hA, 4'h6, 0, 0, 4'h3);
    add("mov_a_b",     1, 1, 8'h10, 4'h0, 4'hA, 4'hA, 4'h6, 0, 0, 4'h0);
    add("add_b_f",     1, 1, 8'h5F, 4'h0, 4'hA, 4'h9, 4'h6, 1, 0, 4'hF);
    add("in_b",        1, 1, 8'h60, 4'h4, 4'hA, 4'h4, 4'h6, 0, 0, 4'h0);
    add("mov_b_3",     1, 1, 8'h73, 4'h0, 4'hA, 4'h3, 4'h6, 0, 0, 4'h3);
    add("out_5",       1, 1, 8'hB5, 4'h0, 4'hA, 4'h3, 4'h5, 0, 0, 4'h5);
    add("mov_a_f",     1, 1, 8'h3F, 4'h0, 4'hF, 4'h3, 4'h5, 0, 0, 4'hF);
    add("add_a_a",     1, 1, 8'h0A, 4'h0, 4'h9, 4'h3, 4'h5, 1, 0, 4'hA);
    add("mid_reset",   0, 1, 8'h05, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h5);
    add("post_jnc",    1, 1, 8'hE4, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 4'h4);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].name, vecs[i].rst_n, vecs[i].en, vecs[i].instr, vecs[i].in_port,
           pk(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].c, vecs[i].pcl, vecs[i].pcd));

    // Randomised program against an instruction-level model.
    m_a = 4'h0; m_b = 4'h0; m_o = 4'h0; m_c = 1'b0;
    for (int k = 0; k < 300; k++) begin
      logic [7:0] ri;
      logic [3:0] rp;
      logic       re;
      logic       rr;
      logic [3:0] op;
      logic [3:0] im;
      logic [4:0] t;
      logic       l;
      ri = 8'($urandom_range(0, 255));
      rp = 4'($urandom_range(0, 15));
      re = ($urandom_range(0, 7) != 0);
      rr = ($urandom_range(0, 31) != 0);
      op = ri[7:4];
      im = ri[3:0];
      l  = rr & re & ((op == 4'hF) | ((op == 4'hE) & ~m_c));
      if (!rr) begin
        m_a = 4'h0; m_b = 4'h0; m_o = 4'h0; m_c = 1'b0;
      end else if (re) begin
        m_c = 1'b0;
        case (op)
          4'h0: begin t = {1'b0, m_a} + {1'b0, im}; m_a = t[3:0]; m_c = t[4]; end
          4'h1: m_a = m_b;
          4'h2: m_a = rp;
          4'h3: m_a = im;
          4'h4: m_b = m_a;
          4'h5: begin t = {1'b0, m_b} + {1'b0, im}; m_b = t[3:0]; m_c = t[4]; end
          4'h6: m_b = rp;
          4'h7: m_b = im;
          4'h9: m_o = m_b;
          4'hB: m_o = im;
          default: ;
        endcase
      end
      step("random", rr, re, ri, rp, pk(m_a, m_b, m_o, m_c, l, im));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
